opl3_write_sched: RTL

Paced, arbitrated write front-end for the OPL3 register port. It accepts register writes from two requesters: A, the CPU/ISA decode path, and B, an internal sequencer such as a MIDI-to-FM driver. Writes are queued in a shared FIFO and replayed onto the OPL3 `addr/din/we` bus as address-port/data-port pairs. Each pair observes the OPL3 settle times, counted in `ce_1us` ticks, so software or sequencer bursts never violate chip write spacing.

---
 rtl/opl3_write_sched.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/opl3_write_sched.sv
// opl3_write_sched
// Paced, arbitrated write front-end for the OPL3 register port. Two
// requesters (A: CPU/ISA decode, B: internal sequencer) push register writes
// into a shared FIFO. Each entry is replayed onto the OPL3 bus as an
// address-port write followed by a data-port write, with idle gaps measured
// in ce_1us ticks. The address write is skipped when the chip already holds
// the same {bank, index} from the previous pair.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   ce_1us            one-cycle pulse every microsecond
//   a_* / b_*         requester write channels (valid/ready, bank, index, data)
//   flush             drop queued entries and abort the pair in progress
//   opl_addr/din/we   OPL3 bus (addr bit1 = bank, bit0 = data port select)
//   busy              FIFO non-empty or FSM active (registered)
//   level             FIFO occupancy (registered)
//   dbg_state         current FSM state encoding
//
// Handshake: a write is transferred on a rising clk edge where x_valid and
// x_ready are both high. x_ready is combinational from the registered FIFO
// level, the round-robin pointer, both valids and flush; a requester must hold
// valid and its payload stable until that edge.
module opl3_write_sched #(
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned ADDR_WAIT_US = 4,
  parameter int unsigned DATA_WAIT_US = 23,
  parameter int unsigned WE_CYCLES    = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ce_1us,
  input  logic                        a_valid,
  output logic                        a_ready,
  input  logic                        a_bank,
  input  logic [7:0]                  a_index,
  input  logic [7:0]                  a_data,
  input  logic                        b_valid,
  output logic                        b_ready,
  input  logic                        b_bank,
  input  logic [7:0]                  b_index,
  input  logic [7:0]                  b_data,
  input  logic                        flush,
  output logic [1:0]                  opl_addr,
  output logic [7:0]                  opl_din,
  output logic                        opl_we,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic [2:0]                  dbg_state
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam logic [3:0]  WE_LAST = 4'(WE_CYCLES - 1);
  // A nonzero wait loads one extra count: the first tick after entry may
  // arrive at any point of a microsecond, so it only opens the window and the
  // remaining N ticks are full microseconds of idle bus.
  localparam logic [15:0] ADDR_LOAD = 16'((ADDR_WAIT_US == 0) ? 0 : ADDR_WAIT_US + 1);
  localparam logic [15:0] DATA_LOAD = 16'((DATA_WAIT_US == 0) ? 0 : DATA_WAIT_US + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ADDR_WR   = 3'd1,
    ADDR_WAIT = 3'd2,
    DATA_WR   = 3'd3,
    DATA_WAIT = 3'd4
  } state_t;

  state_t        state, state_nx;
  logic [16:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level_nx;
  logic          full, empty, push, pop, sel_b, prio_b;
  logic          grant_a, grant_b, cached;
  logic [16:0]   push_entry, head, hold;
  logic [8:0]    last_key;
  logic          last_ok;
  logic [3:0]    we_cnt;
  logic [15:0]   wait_cnt;

  assign dbg_state = state;
  assign full      = (level == LW'(FIFO_DEPTH));
  assign empty     = (level == '0);

  // Round robin: prio_b means B wins a tie; it flips to the requester that
  // was not just served.
  assign grant_a = a_valid && (!b_valid || !prio_b);
  assign grant_b = b_valid && (!a_valid || prio_b);
  assign a_ready = rst_n && !flush && !full && grant_a;
  assign b_ready = rst_n && !flush && !full && grant_b;

  assign sel_b      = b_valid && b_ready;
  assign push       = (a_valid && a_ready) || sel_b;
  assign push_entry = sel_b ? {b_bank, b_index, b_data} : {a_bank, a_index, a_data};
  assign head       = mem[rd_ptr];
  assign cached     = last_ok && (head[16:8] == last_key);
  assign level_nx   = flush ? '0 : (level + LW'(push) - LW'(pop));

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          state_nx = cached ? DATA_WR : ADDR_WR;
        end
      end
      ADDR_WR:   if (we_cnt == WE_LAST) state_nx = ADDR_WAIT;
      ADDR_WAIT: if (wait_cnt == '0)    state_nx = DATA_WR;
      DATA_WR:   if (we_cnt == WE_LAST) state_nx = DATA_WAIT;
      DATA_WAIT: if (wait_cnt == '0)    state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
    if (flush) begin
      state_nx = IDLE;
      pop      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      we_cnt   <= '0;
      wait_cnt <= '0;
      hold     <= '0;
      last_key <= '0;
      last_ok  <= 1'b0;
    end else begin
      state <= state_nx;
      if (pop) hold <= head;
      if ((state == ADDR_WR || state == DATA_WR) && state_nx == state)
        we_cnt <= we_cnt + 4'd1;
      else
        we_cnt <= '0;
      if (state_nx == ADDR_WAIT && state != ADDR_WAIT)
        wait_cnt <= ADDR_LOAD;
      else if (state_nx == DATA_WAIT && state != DATA_WAIT)
        wait_cnt <= DATA_LOAD;
      else if (ce_1us && wait_cnt != '0)
        wait_cnt <= wait_cnt - 16'd1;
      // An aborted address write may have left the chip latch undefined,
      // so a flush always forgets the cached key.
      if (flush)
        last_ok <= 1'b0;
      else if (state == ADDR_WR && state_nx == ADDR_WAIT) begin
        last_key <= hold[16:8];
        last_ok  <= 1'b1;
      end
    end
  end

  // Bus outputs are registered from the current state, so the bus trails the
  // FSM by one cycle; flush forces we low on the very next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opl_we   <= 1'b0;
      opl_addr <= '0;
      opl_din  <= '0;
    end else begin
      opl_we <= !flush && (state == ADDR_WR || state == DATA_WR);
      if (!flush && state == ADDR_WR) begin
        opl_addr <= {hold[16], 1'b0};
        opl_din  <= hold[15:8];
      end else if (!flush && state == DATA_WR) begin
        opl_addr <= {hold[16], 1'b1};
        opl_din  <= hold[7:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      busy   <= 1'b0;
      prio_b <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end
      if (push) prio_b <= !sel_b;
      level <= level_nx;
      busy  <= (level_nx != '0) || (state_nx != IDLE);
    end
  end

endmodule
